regfile_writeback_unit: RTL and testbench

Writeback-side driver for the register file write port. It merges single-cycle ALU results with multi-cycle load results, buffers loads in a small FIFO, and presents at most one registered write per cycle on the register file's write-enable, destination-select and data ports. It also keeps a per-register busy scoreboard for outstanding loads, so the issue stage can stall on read-after-write hazards.

---
 rtl/regfile_writeback_unit.sv | 180 ++++++++++++++++++
 tb/tb_regfile_writeback_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit
//
// Writeback-side driver for the register file write port. Single-cycle ALU results and
// multi-cycle load results are merged onto one registered write port. Loads are buffered in
// a small FIFO. A per-register busy scoreboard tracks outstanding loads so that issue can stall
// on read-after-write hazards.
//
// Parameters:
//   FIFO_DEPTH         load-result buffer entries (power of two, >= 2)
//
// Ports:
//   clk_i, rst_i                         clock (rising edge), async active-high reset
//   alu_valid_i/alu_rd_i/alu_data_i      ALU result, no backpressure
//   lsu_valid_i/lsu_ready_o/lsu_rd_i/lsu_data_i   load result handshake
//   issue_mark_i/issue_rd_i              load issued; marks its destination busy
//   rs1_i/rs2_i, rs1_busy_o/rs2_busy_o   combinational scoreboard lookup
//   stall_o                              registered; FIFO owns the write port while high
//   rf_write_enable_o/rf_reg_select_d_o/rf_reg_data_d_o   registered write port
//   rsN_fwd_valid_o/rsN_fwd_data_o       bypass of the in-flight write
//
// Optional feature: define WB_BYPASS_EN to build the bypass comparators. When undefined the
// forwarding outputs are tied to zero.

module regfile_writeback_unit #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  input  logic        issue_mark_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        stall_o,
  output logic        rf_write_enable_o,
  output logic [4:0]  rf_reg_select_d_o,
  output logic [31:0] rf_reg_data_d_o,
  output logic        rs1_fwd_valid_o,
  output logic        rs2_fwd_valid_o,
  output logic [31:0] rs1_fwd_data_o,
  output logic [31:0] rs2_fwd_data_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull     = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntStallSet = CntW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] CntStallClr = CntW'(1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            stall_q, stall_d;
  logic [31:0]     busy_q, busy_d;
  logic            we_q, we_d;
  logic [4:0]      sel_q, sel_d;
  logic [31:0]     data_q, data_d;

  logic   alu_sel, push, pop, full;
  entry_t head;

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CntFull);
  // ALU results offered while stalled are a protocol violation and are dropped here.
  assign alu_sel = alu_valid_i && !stall_q;
  assign pop     = !alu_sel && (count_q != '0);
  assign lsu_ready_o = !full && !rst_i;
  assign push    = lsu_valid_i && lsu_ready_o;

  assign count_d = count_q + CntW'(push) - CntW'(pop);

  // Hysteresis: raise near full, drop only once nearly drained.
  always_comb begin
    stall_d = stall_q;
    if (count_d >= CntStallSet) begin
      stall_d = 1'b1;
    end else if (count_d <= CntStallClr) begin
      stall_d = 1'b0;
    end
  end

  // Set beats clear when an issue and the write of the same register coincide.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head.rd] = 1'b0;
    end
    if (issue_mark_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Select/data hold their last real write; x0 writes never reach the port.
  always_comb begin
    we_d   = 1'b0;
    sel_d  = sel_q;
    data_d = data_q;
    if (alu_sel) begin
      if (alu_rd_i != 5'd0) begin
        we_d   = 1'b1;
        sel_d  = alu_rd_i;
        data_d = alu_data_i;
      end
    end else if (pop) begin
      if (head.rd != 5'd0) begin
        we_d   = 1'b1;
        sel_d  = head.rd;
        data_d = head.data;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{rd: lsu_rd_i, data: lsu_data_i};
    end
  end

  assign stall_o           = stall_q;
  assign rf_write_enable_o = we_q;
  assign rf_reg_select_d_o = sel_q;
  assign rf_reg_data_d_o   = data_q;
  assign rs1_busy_o        = busy_q[rs1_i];
  assign rs2_busy_o        = busy_q[rs2_i];

`ifdef WB_BYPASS_EN
  // Covers the cycle before the register file reflects the write.
  assign rs1_fwd_valid_o = we_q && (sel_q == rs1_i) && (rs1_i != 5'd0);
  assign rs2_fwd_valid_o = we_q && (sel_q == rs2_i) && (rs2_i != 5'd0);
  assign rs1_fwd_data_o  = data_q;
  assign rs2_fwd_data_o  = data_q;
`else
  assign rs1_fwd_valid_o = 1'b0;
  assign rs2_fwd_valid_o = 1'b0;
  assign rs1_fwd_data_o  = '0;
  assign rs2_fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb_regfile_writeback_unit
//
// Directed bench for regfile_writeback_unit (FIFO_DEPTH = 4). Inputs change 1 time unit after
// a rising edge; outputs are checked at the same point, i.e. during the cycle after the edge.

module tb_regfile_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_mark;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_sel;
  logic [31:0] rf_data;
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback_unit #(.FIFO_DEPTH(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .alu_valid_i       (alu_valid),
    .alu_rd_i          (alu_rd),
    .alu_data_i        (alu_data),
    .lsu_valid_i       (lsu_valid),
    .lsu_ready_o       (lsu_ready),
    .lsu_rd_i          (lsu_rd),
    .lsu_data_i        (lsu_data),
    .issue_mark_i      (issue_mark),
    .issue_rd_i        (issue_rd),
    .rs1_i             (rs1),
    .rs2_i             (rs2),
    .rs1_busy_o        (rs1_busy),
    .rs2_busy_o        (rs2_busy),
    .stall_o           (stall),
    .rf_write_enable_o (rf_we),
    .rf_reg_select_d_o (rf_sel),
    .rf_reg_data_d_o   (rf_data),
    .rs1_fwd_valid_o   (rs1_fwd_valid),
    .rs2_fwd_valid_o   (rs2_fwd_valid),
    .rs1_fwd_data_o    (rs1_fwd_data),
    .rs2_fwd_data_o    (rs2_fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] sel,
                        input logic [31:0] data);
    chk({tag, ".we"}, 32'(rf_we), 32'(we));
    chk({tag, ".sel"}, 32'(rf_sel), 32'(sel));
    chk({tag, ".data"}, rf_data, data);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_mark = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0;

    // Reset state
    step();
    step();
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.ready", 32'(lsu_ready), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.fwd1", 32'(rs1_fwd_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("rel.ready", 32'(lsu_ready), 32'd1);
    chk("rel.we", 32'(rf_we), 32'd0);

    // ALU write to x5, exactly one cycle
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    chk_wr("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk("alu5.one", 32'(rf_we), 32'd0);

    // ALU write to x0 is discarded
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    step();
    alu_valid = 1'b0;
    chk_wr("alu0", 1'b0, 5'd5, 32'hDEADBEEF);

    // ALU x3 and load x7 at the same edge: ALU first
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk_wr("prio.alu", 1'b1, 5'd3, 32'h33);
    step();
    chk_wr("prio.ld", 1'b1, 5'd7, 32'h77);
    step();
    chk("prio.idle", 32'(rf_we), 32'd0);

    // Scoreboard: set, clear on load write
    issue_mark = 1'b1; issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd9;
    step();
    issue_mark = 1'b0;
    chk("sb.set1", 32'(rs1_busy), 32'd1);
    chk("sb.set2", 32'(rs2_busy), 32'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    step();
    lsu_valid = 1'b0;
    chk("sb.pushed.we", 32'(rf_we), 32'd0);
    chk("sb.pending", 32'(rs1_busy), 32'd1);
    step();
    chk_wr("sb.wr9", 1'b1, 5'd9, 32'h99);
    chk("sb.clr", 32'(rs1_busy), 32'd0);

    // Scoreboard: new issue coinciding with the write keeps busy
    issue_mark = 1'b1; issue_rd = 5'd9;
    step();
    issue_mark = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h199;
    step();
    lsu_valid = 1'b0;
    issue_mark = 1'b1; issue_rd = 5'd9;
    step();
    issue_mark = 1'b0;
    chk_wr("sb.wr9b", 1'b1, 5'd9, 32'h199);
    chk("sb.setwins", 32'(rs1_busy), 32'd1);

    // x0 never busy
    issue_mark = 1'b1; issue_rd = 5'd0; rs2 = 5'd0;
    step();
    issue_mark = 1'b0;
    chk("sb.x0", 32'(rs2_busy), 32'd0);

    // Stall: four loads with ALU continuously valid
    alu_valid = 1'b1; alu_rd = 5'd1;
    lsu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'hA0 + 32'(i);
      lsu_rd = 5'(20 + i); lsu_data = 32'h2000_0000 + 32'(20 + i);
      step();
      chk_wr("st.alu", 1'b1, 5'd1, 32'hA0 + 32'(i));
      chk("st.stall", 32'(stall), (i == 2) ? 32'd1 : 32'd0);
    end
    // ALU kept asserted while stalled: must be ignored
    alu_data = 32'hBAD;
    lsu_rd = 5'd23; lsu_data = 32'h2000_0017;
    step();
    lsu_valid = 1'b0;
    chk_wr("st.d20", 1'b1, 5'd20, 32'h2000_0014);
    chk("st.stall4", 32'(stall), 32'd1);
    chk("st.ready", 32'(lsu_ready), 32'd1);
    step();
    chk_wr("st.d21", 1'b1, 5'd21, 32'h2000_0015);
    chk("st.stall5", 32'(stall), 32'd1);
    step();
    alu_valid = 1'b0;
    chk_wr("st.d22", 1'b1, 5'd22, 32'h2000_0016);
    chk("st.unstall", 32'(stall), 32'd0);
    step();
    chk_wr("st.d23", 1'b1, 5'd23, 32'h2000_0017);
    step();
    chk("st.empty", 32'(rf_we), 32'd0);

    // Bypass of an in-flight write to x12
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hCAFE0012;
    rs1 = 5'd13; rs2 = 5'd12;
    step();
    alu_valid = 1'b0;
`ifdef WB_BYPASS_EN
    chk("byp.v2", 32'(rs2_fwd_valid), 32'd1);
    chk("byp.d2", rs2_fwd_data, 32'hCAFE0012);
`else
    chk("byp.v2", 32'(rs2_fwd_valid), 32'd0);
    chk("byp.d2", rs2_fwd_data, 32'h0);
`endif
    chk("byp.v1", 32'(rs1_fwd_valid), 32'd0);

    // Reset mid-stream with two loads buffered (ALU holds the port)
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1;
    lsu_rd = 5'd14; lsu_data = 32'h14;
    step();
    lsu_rd = 5'd15; lsu_data = 32'h15;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rs1 = 5'd9;
    chk("mid.we", 32'(rf_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_wr("mid.rst", 1'b0, 5'd0, 32'h0);
    chk("mid.ready", 32'(lsu_ready), 32'd0);
    chk("mid.busy", 32'(rs1_busy), 32'd0);
    chk("mid.stall", 32'(stall), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post.we", 32'(rf_we), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
